lcd_message_writer: RTL

Downstream consumer of the reaction timer's LCD request interface. Accepts a level-held `LCDUpdate` request with the `Wait`/`Cheat`/`Slow` flags and the 10-bit `ReactionTime`, renders a 16-character line-1 message, and drives an HD44780-compatible character LCD over an 8-bit write-only bus. After the last character it returns a one-cycle `LCDAck`. It also runs the LCD power-up initialisation sequence after reset.

---
 rtl/lcd_msg_pkg.sv | 91 +++++++++
 rtl/lcd_message_writer_bcd.sv | 43 ++++
 rtl/lcd_message_writer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/lcd_msg_pkg.sv
// lcd_msg_pkg: state encoding, LCD command bytes, message select and
// character ROM shared by lcd_message_writer and its BCD converter.
package lcd_msg_pkg;

    localparam int BIN_W = 10;

    typedef enum logic [3:0] {
        S_PowerWait,
        S_InitCmd,
        S_Idle,
        S_Convert,
        S_Setup,
        S_Pulse,
        S_Hold,
        S_Ack,
        S_Rearm
    } state_t;

    typedef enum logic [1:0] {
        PH_INIT,
        PH_LINE1,
        PH_LINE2
    } phase_t;

    typedef enum logic [2:0] {
        MSG_CHEAT,
        MSG_SLOW,
        MSG_WAIT,
        MSG_TIME,
        MSG_BEST,
        MSG_NOBEST
    } msg_t;

    localparam logic [7:0] CMD_FUNC  = 8'h38;
    localparam logic [7:0] CMD_DISP  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;

    localparam logic [127:0] TXT_CHEAT  = "CHEATER!        ";
    localparam logic [127:0] TXT_SLOW   = "TOO SLOW        ";
    localparam logic [127:0] TXT_WAIT   = "WAIT FOR LEDS   ";
    localparam logic [127:0] TXT_TIME   = "TIME: 0000 ms   ";
    localparam logic [127:0] TXT_BEST   = "BEST: 0000 ms   ";
    localparam logic [127:0] TXT_NOBEST = "BEST: ---- ms   ";

    function automatic logic [7:0] init_cmd(logic [1:0] i);
        logic [7:0] c;
        unique case (i)
            2'd0: c = CMD_FUNC;
            2'd1: c = CMD_DISP;
            2'd2: c = CMD_ENTRY;
            2'd3: c = CMD_CLEAR;
        endcase
        return c;
    endfunction

    function automatic msg_t msg_select(logic cheat, logic slow,
                                        logic wait_flag);
        if (cheat)
            return MSG_CHEAT;
        if (slow)
            return MSG_SLOW;
        if (wait_flag)
            return MSG_WAIT;
        return MSG_TIME;
    endfunction

    // Digit columns 6..9 of the time templates come from the BCD value.
    function automatic logic [7:0] msg_char(msg_t m, logic [3:0] pos,
                                            logic [15:0] bcd);
        logic [127:0] t;
        logic [7:0]   c;
        int           p;
        unique case (m)
            MSG_CHEAT:  t = TXT_CHEAT;
            MSG_SLOW:   t = TXT_SLOW;
            MSG_WAIT:   t = TXT_WAIT;
            MSG_BEST:   t = TXT_BEST;
            MSG_NOBEST: t = TXT_NOBEST;
            default:    t = TXT_TIME;
        endcase
        p = 8 * (15 - int'(pos));
        c = t[p +: 8];
        if ((m == MSG_TIME || m == MSG_BEST) &&
            pos >= 4'd6 && pos <= 4'd9)
            c = {4'h3, bcd[4 * (9 - int'(pos)) +: 4]};
        return c;
    endfunction

endpackage

// File: rtl/lcd_message_writer_bcd.sv
// bin2bcd_seq: 10-bit sequential double-dabble, one bit per cycle.
// done is high in the cycle whose closing edge performs the last shift.
module bin2bcd_seq
    import lcd_msg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [15:0]      bcd
);

    logic [BIN_W-1:0] shreg;
    logic [15:0]      adj;
    logic [3:0]       cnt;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 4; i++)
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            bcd   <= '0;
            cnt   <= '0;
        end else if (start) begin
            shreg <= bin;
            bcd   <= '0;
            cnt   <= 4'(BIN_W);
        end else if (cnt != 4'd0) begin
            bcd   <= {adj[14:0], shreg[BIN_W-1]};
            shreg <= {shreg[BIN_W-2:0], 1'b0};
            cnt   <= cnt - 4'd1;
        end
    end

    assign done = (cnt == 4'd1);

endmodule

// File: rtl/lcd_message_writer.sv
// lcd_message_writer: renders reaction-timer results on an HD44780 LCD.
// Define LCD_BEST_EN to add the best-time line on row 2.
module lcd_message_writer
    import lcd_msg_pkg::*;
#(
    parameter int EN_PULSE_CYC  = 2,
    parameter int CMD_WAIT_CYC  = 2,
    parameter int INIT_WAIT_CYC = 50
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       LCDUpdate,
    input  logic       Wait,
    input  logic       Cheat,
    input  logic       Slow,
    input  logic [9:0] ReactionTime,
    output logic       LCDAck,
    output logic       Busy,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_Data
);

    state_t      state, next_state;
    phase_t      phase;
    msg_t        msg_q, line2_msg;
    logic [9:0]  time_q, best_new, bcd_bin;
    logic [4:0]  idx;
    logic [15:0] cnt, bcd;
    logic        bcd_start, bcd_done;
    logic        wait_end, pulse_end, hold_end, seq_end, line2_next;
    logic        in_write, wr_rs;
    logic [7:0]  wr_byte;
    logic [3:0]  pos;

    bin2bcd_seq u_bcd (
        .clk   (Clk),
        .rst_n (Rst),
        .start (bcd_start),
        .bin   (bcd_bin),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    // S_InitCmd is the final power-up wait cycle, so it takes one off here.
    assign wait_end  = int'(cnt) >= INIT_WAIT_CYC - 2;
    assign pulse_end = int'(cnt) >= EN_PULSE_CYC - 1;
    assign hold_end  = int'(cnt) >= CMD_WAIT_CYC - 1;
    assign seq_end   = (phase == PH_INIT) ? (idx == 5'd3) : (idx == 5'd16);

`ifdef LCD_BEST_EN
    logic [9:0] best_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            best_q <= 10'h3FF;
        else if (state == S_Hold && hold_end && seq_end &&
                 phase == PH_LINE1)
            best_q <= best_new;
    end

    assign best_new   = (msg_q == MSG_TIME && time_q < best_q) ?
                        time_q : best_q;
    assign line2_next = (phase == PH_LINE1);
    assign line2_msg  = (best_q == 10'h3FF) ? MSG_NOBEST : MSG_BEST;
`else
    assign best_new   = time_q;
    assign line2_next = 1'b0;
    assign line2_msg  = MSG_NOBEST;
`endif

    always_comb begin
        next_state = state;
        bcd_start  = 1'b0;
        bcd_bin    = time_q;
        unique case (state)
            S_PowerWait: if (wait_end) next_state = S_InitCmd;
            S_InitCmd:   next_state = S_Setup;
            S_Idle: begin
                if (LCDUpdate) begin
                    next_state = S_Convert;
                    bcd_start  = 1'b1;
                    bcd_bin    = ReactionTime;
                end
            end
            S_Convert:   if (bcd_done) next_state = S_Setup;
            S_Setup:     next_state = S_Pulse;
            S_Pulse:     if (pulse_end) next_state = S_Hold;
            S_Hold: begin
                if (hold_end) begin
                    if (!seq_end)
                        next_state = S_Setup;
                    else if (phase == PH_INIT)
                        next_state = S_Idle;
                    else if (line2_next) begin
                        next_state = S_Convert;
                        bcd_start  = 1'b1;
                        bcd_bin    = best_new;
                    end else
                        next_state = S_Ack;
                end
            end
            S_Ack:       next_state = S_Rearm;
            S_Rearm:     if (!LCDUpdate) next_state = S_Idle;
            default:     next_state = S_PowerWait;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state  <= S_PowerWait;
            cnt    <= '0;
            idx    <= '0;
            phase  <= PH_INIT;
            msg_q  <= MSG_TIME;
            time_q <= '0;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state) ? '0 : cnt + 16'd1;
            if (state == S_InitCmd) begin
                phase <= PH_INIT;
                idx   <= '0;
            end
            if (state == S_Idle && LCDUpdate) begin
                phase  <= PH_LINE1;
                idx    <= '0;
                time_q <= ReactionTime;
                msg_q  <= msg_select(Cheat, Slow, Wait);
            end
            if (state == S_Hold && hold_end) begin
                if (!seq_end)
                    idx <= idx + 5'd1;
                else if (line2_next) begin
                    phase <= PH_LINE2;
                    idx   <= '0;
                end
            end
        end
    end

    // Index 0 of each line is its command; 1..16 are the characters.
    assign pos = idx[3:0] - 4'd1;

    always_comb begin
        wr_byte = 8'h00;
        wr_rs   = 1'b0;
        unique case (phase)
            PH_INIT: wr_byte = init_cmd(idx[1:0]);
            PH_LINE1: begin
                if (idx == 5'd0)
                    wr_byte = CMD_CLEAR;
                else begin
                    wr_rs   = 1'b1;
                    wr_byte = msg_char(msg_q, pos, bcd);
                end
            end
            PH_LINE2: begin
                if (idx == 5'd0)
                    wr_byte = CMD_LINE2;
                else begin
                    wr_rs   = 1'b1;
                    wr_byte = msg_char(line2_msg, pos, bcd);
                end
            end
            default: ;
        endcase
    end

    assign in_write = (state == S_Setup) || (state == S_Pulse) ||
                      (state == S_Hold);
    assign LCD_Data = in_write ? wr_byte : 8'h00;
    assign LCD_RS   = in_write & wr_rs;
    assign LCD_E    = (state == S_Pulse);
    assign LCD_RW   = 1'b0;
    assign LCDAck   = (state == S_Ack);
    assign Busy     = (state != S_Idle);

endmodule
